// File: rtl/mac_array_ctrl_if.sv
// Job-control bundle between a requester and mac_array_ctrl: job request,
// output-FIFO back-pressure, status, memory read strobes and column-0 instruction.
interface mac_array_ctrl_if #(
    parameter int addr_bw = 4
);
    logic               start;
    logic [addr_bw-1:0] num_q;
    logic               ofifo_full;
    logic               busy;
    logic               done;
    logic               arr_rst;
    logic               kmem_rd;
    logic [addr_bw-1:0] kmem_addr;
    logic               qmem_rd;
    logic [addr_bw-1:0] qmem_addr;
    logic [1:0]         inst_w;

    modport master (
        output start, num_q, ofifo_full,
        input  busy, done, arr_rst, kmem_rd, kmem_addr, qmem_rd, qmem_addr, inst_w
    );

    modport slave (
        input  start, num_q, ofifo_full,
        output busy, done, arr_rst, kmem_rd, kmem_addr, qmem_rd, qmem_addr, inst_w
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the mac_col array: clear, key load, query execute with
// output-FIFO stall, pipeline drain, done pulse.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; num_q latched when start seen
//   S_CLR   | one-cycle arr_rst pulse to clear the column load counters
//   S_LOAD  | load_cyc key reads, kmem_addr = 0,1,..
//   S_EXEC  | num_q query reads, one per cycle unless ofifo_full
//   S_DRAIN | drain_cyc idle cycles for the array pipeline to empty
//   S_DONE  | one-cycle done pulse
module mac_array_ctrl #(
    parameter int col       = 8,
    parameter int addr_bw   = 4,
    parameter int load_cyc  = 10,
    parameter int drain_cyc = 10
) (
    input logic             clk,
    input logic             reset,
    mac_array_ctrl_if.slave bus
);
    if (col < 1 || load_cyc < 1 || drain_cyc < 1) begin : g_param_chk
        $error("mac_array_ctrl: col, load_cyc and drain_cyc must be >= 1");
    end

    // Index counter serves both the key address and the query issue count, so it
    // must hold 2^addr_bw (one past the largest num_q) without wrapping.
    localparam int idx_max = (load_cyc > (1 << addr_bw)) ? load_cyc : (1 << addr_bw);
    localparam int idx_bw  = $clog2(idx_max + 1);
    localparam int tmr_bw  = $clog2(drain_cyc + 1);

    localparam logic [idx_bw-1:0] load_last  = idx_bw'(load_cyc - 1);
    localparam logic [tmr_bw-1:0] drain_last = tmr_bw'(drain_cyc - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [idx_bw-1:0]  idx;
    logic [idx_bw-1:0]  idx_inc;
    logic [tmr_bw-1:0]  tmr;
    logic [addr_bw-1:0] num_q_q;
    logic [1:0]         inst_w_q;

    logic               busy_c, done_c, arr_rst_c, kmem_rd_c, qmem_rd_c;
    logic [addr_bw-1:0] kmem_addr_c, qmem_addr_c;

    assign idx_inc = idx + idx_bw'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CLR;
            S_CLR:   state_nxt = S_LOAD;
            S_LOAD:  if (idx == load_last) state_nxt = (num_q_q == '0) ? S_DRAIN : S_EXEC;
            S_EXEC:  if (!bus.ofifo_full && idx_inc == idx_bw'(num_q_q)) state_nxt = S_DRAIN;
            S_DRAIN: if (tmr == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            tmr     <= '0;
            num_q_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (bus.start) num_q_q <= bus.num_q;
                end
                S_CLR:  idx <= '0;
                S_LOAD: idx <= (idx == load_last) ? '0 : idx_inc;
                S_EXEC: if (!bus.ofifo_full) idx <= idx_inc;
                default: ;
            endcase
            // Drain timer counts down to zero; preloaded in every other state.
            tmr <= (state == S_DRAIN) ? tmr - tmr_bw'(1) : drain_last;
        end
    end

    always_comb begin
        busy_c      = (state != S_IDLE);
        done_c      = 1'b0;
        arr_rst_c   = 1'b0;
        kmem_rd_c   = 1'b0;
        kmem_addr_c = '0;
        qmem_rd_c   = 1'b0;
        qmem_addr_c = '0;
        case (state)
            S_CLR:  arr_rst_c = 1'b1;
            S_LOAD: begin
                kmem_rd_c   = 1'b1;
                kmem_addr_c = idx[addr_bw-1:0];
            end
            S_EXEC: begin
                qmem_rd_c   = !bus.ofifo_full;
                qmem_addr_c = idx[addr_bw-1:0];
            end
            S_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // inst_w trails the read strobes by one cycle to meet the returning memory data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_w_q <= 2'b00;
        end else begin
            inst_w_q <= {qmem_rd_c, kmem_rd_c};
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.arr_rst   = arr_rst_c;
    assign bus.kmem_rd   = kmem_rd_c;
    assign bus.kmem_addr = kmem_addr_c;
    assign bus.qmem_rd   = qmem_rd_c;
    assign bus.qmem_addr = qmem_addr_c;
    assign bus.inst_w    = inst_w_q;
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: per-cycle output checks of whole jobs
// against a timeline model built from the hand-derived job schedule.
module tb_mac_array_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mac_array_ctrl_if #(.addr_bw(4)) bus ();

    mac_array_ctrl #(
        .col(8), .addr_bw(4), .load_cyc(10), .drain_cyc(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, done, arr_rst, kmem_rd, kmem_addr, qmem_rd, qmem_addr, inst_w}
    function automatic logic [14:0] outs();
        return {bus.busy, bus.done, bus.arr_rst, bus.kmem_rd, bus.kmem_addr,
                bus.qmem_rd, bus.qmem_addr, bus.inst_w};
    endfunction

    // Job timeline: cycle 1 CLR, 2..11 LOAD, 12.. EXEC (nq issues plus sl stall
    // cycles after the sa-th issue), then 10 DRAIN cycles, DONE at exp_done.
    task automatic run_job(input string nm, input int nq, input int sa, input int sl,
                           input int exp_done, input bit hold);
        logic [1:0]  prev;
        logic [14:0] e;
        logic        krd, qrd, stall, in_exec;
        logic [3:0]  kaddr, qaddr;
        int          k, ex_len, sl_eff;
        bus.num_q = 4'(nq);
        bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        bus.num_q = 4'(nq ^ 5);
        prev = 2'b00;
        sl_eff = (nq > sa) ? sl : 0;
        ex_len = nq + sl_eff;
        for (int c = 1; c <= exp_done + 1; c++) begin
            krd     = (c >= 2 && c <= 11);
            kaddr   = krd ? 4'(c - 2) : 4'd0;
            k       = c - 12;
            in_exec = (k >= 0 && k < ex_len);
            stall   = in_exec && sl_eff > 0 && k >= sa && k < sa + sl_eff;
            qrd     = in_exec && !stall;
            if (!in_exec)       qaddr = 4'd0;
            else if (stall)     qaddr = 4'(sa);
            else if (k >= sa + sl_eff) qaddr = 4'(k - sl_eff);
            else                qaddr = 4'(k);
            bus.ofifo_full = stall || c == 3 || c == exp_done - 2;
            e = {(c <= exp_done), (c == exp_done), (c == 1), krd, kaddr, qrd, qaddr, prev};
            #1;
            chk($sformatf("%s cyc%0d", nm, c), 32'(outs()), 32'(e));
            prev = {qrd, krd};
            @(posedge clk); #1;
        end
        bus.ofifo_full = 1'b0;
        if (hold) begin
            chk({nm, " restart from idle"}, {30'd0, bus.busy, bus.arr_rst}, 32'd3);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.num_q = 4'd0;
        bus.ofifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'(outs()), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", 32'(outs()), 32'd0);

        run_job("nq4",        4, 0, 0, 26, 1'b0);
        run_job("nq4 stall",  4, 2, 3, 29, 1'b0);
        run_job("nq0",        0, 0, 0, 22, 1'b0);
        run_job("nq15",      15, 0, 0, 37, 1'b0);
        run_job("start held", 4, 0, 0, 26, 1'b1);

        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid load kmem_rd", 32'(bus.kmem_rd), 32'd1);
        reset = 1'b0;
        #1;
        chk("async reset outputs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        chk("reset held outputs", 32'(outs()), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle after abort", 32'(outs()), 32'd0);
        run_job("restart nq3", 3, 0, 0, 25, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
